// File: rtl/output_port_demux.sv
// Output port demux: buffers packet words and fans them out to the ports named in the IOQ header.
// Define OUTPUT_PORT_DEMUX_DROP_CNT_EN to add the num_pkts_dropped counter output.
module output_port_demux #(
  parameter int DATA_WIDTH = 64,
  parameter int CTRL_WIDTH = DATA_WIDTH / 8,
  parameter int NUM_OUTPUT_QUEUES = 8,
  parameter logic [CTRL_WIDTH-1:0] IO_QUEUE_STAGE_NUM = 'hff,
  parameter int DST_PORT_POS = 0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [DATA_WIDTH-1:0]        in_data,
  input  logic [CTRL_WIDTH-1:0]        in_ctrl,
  input  logic                         in_wr,
  output logic                         in_rdy,
  output logic [DATA_WIDTH-1:0]        out_data,
  output logic [CTRL_WIDTH-1:0]        out_ctrl,
  output logic [NUM_OUTPUT_QUEUES-1:0] out_wr,
  input  logic [NUM_OUTPUT_QUEUES-1:0] out_rdy
`ifdef OUTPUT_PORT_DEMUX_DROP_CNT_EN
  ,
  output logic [31:0]                  num_pkts_dropped
`endif
);

  localparam int W = CTRL_WIDTH + DATA_WIDTH;
  localparam int NQ = NUM_OUTPUT_QUEUES;

  typedef enum logic {HDRS, PAYLOAD} state_t;

  logic [W-1:0] fifo_mem [4];
  logic [1:0] wr_ptr;
  logic [1:0] rd_ptr;
  logic [2:0] count;
  logic fifo_wr;
  logic empty;
  logic full;
  logic rd_en;

  logic [CTRL_WIDTH-1:0] head_ctrl;
  logic [DATA_WIDTH-1:0] head_data;

  state_t state;
  state_t state_next;
  logic sop_q;
  logic is_sop;
  logic eop_rd;
  logic [NQ-1:0] sel_q;
  logic [NQ-1:0] dec_sel;
  logic [NQ-1:0] cur_sel;

  assign empty = (count == 3'd0);
  assign full = (count == 3'd4);
  assign fifo_wr = in_wr && !full;
  assign in_rdy = (count < 3'd3);

  assign head_ctrl = fifo_mem[rd_ptr][W-1 -: CTRL_WIDTH];
  assign head_data = fifo_mem[rd_ptr][DATA_WIDTH-1:0];

  always_comb begin
    dec_sel = '0;
    if (head_ctrl == IO_QUEUE_STAGE_NUM)
      dec_sel = head_data[DST_PORT_POS +: NQ];
    is_sop = (state == HDRS) && sop_q;
    // The SOP word is steered by its own freshly decoded header.
    cur_sel = is_sop ? dec_sel : sel_q;
    rd_en = !empty && ((cur_sel & ~out_rdy) == '0);
    eop_rd = rd_en && (state == PAYLOAD) && (head_ctrl != '0);
  end

  always_comb begin
    state_next = state;
    unique case (state)
      HDRS:
        if (rd_en && head_ctrl == '0)
          state_next = PAYLOAD;
      PAYLOAD:
        if (eop_rd)
          state_next = HDRS;
    endcase
  end

  always_ff @(posedge clk) begin
    if (fifo_wr)
      fifo_mem[wr_ptr] <= {in_ctrl, in_data};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      state <= HDRS;
      sop_q <= 1'b1;
      sel_q <= '0;
      out_wr <= '0;
      out_data <= '0;
      out_ctrl <= '0;
    end else begin
      if (fifo_wr)
        wr_ptr <= wr_ptr + 2'd1;
      if (rd_en)
        rd_ptr <= rd_ptr + 2'd1;
      count <= count + {2'b0, fifo_wr} - {2'b0, rd_en};
      state <= state_next;
      out_wr <= rd_en ? cur_sel : '0;
      if (rd_en) begin
        out_data <= head_data;
        out_ctrl <= head_ctrl;
        sel_q <= cur_sel;
        if (eop_rd)
          sop_q <= 1'b1;
        else if (state == HDRS)
          sop_q <= 1'b0;
      end
    end
  end

`ifdef OUTPUT_PORT_DEMUX_DROP_CNT_EN
  always_ff @(posedge clk) begin
    if (reset)
      num_pkts_dropped <= '0;
    else if (rd_en && is_sop && cur_sel == '0 && num_pkts_dropped != 32'hffffffff)
      num_pkts_dropped <= num_pkts_dropped + 32'd1;
  end
`endif

endmodule

// File: tb/tb_output_port_demux.sv
// Bench for output_port_demux: a scoreboard queue of expected port words
// is filled as packets are built and drained by a negedge output monitor.
module tb_output_port_demux;

  localparam int DW = 64;
  localparam int CW = 8;
  localparam int NQ = 8;

  logic clk = 1'b0;
  logic reset;
  logic [DW-1:0] in_data;
  logic [CW-1:0] in_ctrl;
  logic in_wr;
  logic in_rdy;
  logic [DW-1:0] out_data;
  logic [CW-1:0] out_ctrl;
  logic [NQ-1:0] out_wr;
  logic [NQ-1:0] out_rdy;
`ifdef OUTPUT_PORT_DEMUX_DROP_CNT_EN
  logic [31:0] num_pkts_dropped;
`endif

  output_port_demux #(
    .DATA_WIDTH(DW),
    .CTRL_WIDTH(CW),
    .NUM_OUTPUT_QUEUES(NQ)
  ) dut (
    .clk(clk),
    .reset(reset),
    .in_data(in_data),
    .in_ctrl(in_ctrl),
    .in_wr(in_wr),
    .in_rdy(in_rdy),
    .out_data(out_data),
    .out_ctrl(out_ctrl),
    .out_wr(out_wr),
    .out_rdy(out_rdy)
`ifdef OUTPUT_PORT_DEMUX_DROP_CNT_EN
    ,
    .num_pkts_dropped(num_pkts_dropped)
`endif
  );

  always #5 clk = ~clk;

  typedef logic [NQ+CW+DW-1:0] exp_t;
  exp_t exp_q[$];
  logic [CW+DW-1:0] stim_q[$];

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int nwr = 0;
  int first_wr = -1;
  int last_wr = -1;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    exp_t e;
    if (reset === 1'b0 && out_wr !== '0) begin
      nwr++;
      if (first_wr < 0) first_wr = cyc;
      last_wr = cyc;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL out_word: got wr=%h ctrl=%h data=%h, required no write",
                 out_wr, out_ctrl, out_data);
      end else begin
        e = exp_q.pop_front();
        if ({out_wr, out_ctrl, out_data} !== e) begin
          errors++;
          $display("FAIL out_word: got wr=%h ctrl=%h data=%h, required wr=%h ctrl=%h data=%h",
                   out_wr, out_ctrl, out_data,
                   e[NQ+CW+DW-1 -: NQ], e[CW+DW-1 -: CW], e[DW-1:0]);
        end
      end
    end
  end

  function automatic void build_pkt(input logic [15:0] dst, input bit ioq,
                                    input int n, input int lo, input int hi,
                                    input bit expect_out);
    logic [CW-1:0] c;
    logic [DW-1:0] d;
    logic [NQ-1:0] m;
    m = ioq ? dst[NQ-1:0] : '0;
    for (int i = lo; i < hi; i++) begin
      d = {$urandom, $urandom};
      if (i == 0) begin
        c = ioq ? 8'hff : 8'h00;
        if (ioq) d[15:0] = dst;
      end else if (i == n - 1) begin
        c = 8'h01;
      end else begin
        c = 8'h00;
      end
      stim_q.push_back({c, d});
      if (expect_out && m != '0) exp_q.push_back({m, c, d});
    end
  endfunction

  task automatic clear_stats();
    nwr = 0;
    first_wr = -1;
    last_wr = -1;
  endtask

  task automatic drive_all();
    int guard = 0;
    while (stim_q.size() != 0 && guard < 2000) begin
      @(negedge clk);
      guard++;
      if (in_rdy) begin
        {in_ctrl, in_data} = stim_q.pop_front();
        in_wr = 1'b1;
      end else begin
        in_wr = 1'b0;
      end
    end
    @(negedge clk);
    in_wr = 1'b0;
    checks++;
    if (stim_q.size() != 0) begin
      errors++;
      $display("FAIL drive_timeout: %0d words left, required 0", stim_q.size());
      stim_q.delete();
    end
  endtask

  task automatic wait_drain();
    int guard = 0;
    while (exp_q.size() != 0 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    repeat (6) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d words undelivered, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic check_span(input string name, input int n);
    checks++;
    if (nwr != n) begin
      errors++;
      $display("FAIL %s_count: got %0d writes, required %0d", name, nwr, n);
    end
    checks++;
    if (last_wr - first_wr + 1 != n) begin
      errors++;
      $display("FAIL %s_rate: got span %0d cycles, required %0d", name,
               last_wr - first_wr + 1, n);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    in_wr = 1'b0;
    in_data = '0;
    in_ctrl = '0;
    out_rdy = '1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if (out_wr !== '0) begin
      errors++;
      $display("FAIL reset_out_wr: got %h, required 00", out_wr);
    end
    checks++;
    if (out_data !== '0) begin
      errors++;
      $display("FAIL reset_out_data: got %h, required 0", out_data);
    end
    checks++;
    if (out_ctrl !== '0) begin
      errors++;
      $display("FAIL reset_out_ctrl: got %h, required 00", out_ctrl);
    end
    checks++;
    if (in_rdy !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_rdy: got %b, required 1", in_rdy);
    end
`ifdef OUTPUT_PORT_DEMUX_DROP_CNT_EN
    checks++;
    if (num_pkts_dropped !== 32'd0) begin
      errors++;
      $display("FAIL reset_drop_cnt: got %0d, required 0", num_pkts_dropped);
    end
`endif
  endtask

  task automatic test_unicast();
    clear_stats();
    build_pkt(16'h0004, 1'b1, 5, 0, 5, 1'b1);
    drive_all();
    wait_drain();
    check_span("unicast", 5);
  endtask

  task automatic test_multicast_stall();
    out_rdy = 8'hef;
    clear_stats();
    build_pkt(16'h0011, 1'b1, 5, 0, 5, 1'b1);
    fork
      drive_all();
      begin
        repeat (2) @(negedge clk);
        repeat (3) begin
          @(negedge clk);
          checks++;
          if (out_wr !== '0) begin
            errors++;
            $display("FAIL stall_out_wr: got %h, required 00", out_wr);
          end
        end
        out_rdy = '1;
      end
    join
    wait_drain();
    checks++;
    if (nwr != 5) begin
      errors++;
      $display("FAIL multicast_count: got %0d writes, required 5", nwr);
    end
  endtask

  task automatic test_drop();
`ifdef OUTPUT_PORT_DEMUX_DROP_CNT_EN
    logic [31:0] before;
    before = num_pkts_dropped;
`endif
    clear_stats();
    build_pkt(16'h0000, 1'b0, 5, 0, 5, 1'b1);
    build_pkt(16'h0100, 1'b1, 4, 0, 4, 1'b1);
    build_pkt(16'h0000, 1'b1, 3, 0, 3, 1'b1);
    drive_all();
    wait_drain();
    checks++;
    if (nwr != 0) begin
      errors++;
      $display("FAIL drop_count: got %0d writes, required 0", nwr);
    end
`ifdef OUTPUT_PORT_DEMUX_DROP_CNT_EN
    checks++;
    if (num_pkts_dropped !== before + 32'd3) begin
      errors++;
      $display("FAIL drop_cnt: got %0d, required %0d", num_pkts_dropped, before + 32'd3);
    end
`endif
  endtask

  task automatic test_back_to_back();
    clear_stats();
    build_pkt(16'h0002, 1'b1, 4, 0, 4, 1'b1);
    build_pkt(16'h0040, 1'b1, 4, 0, 4, 1'b1);
    drive_all();
    wait_drain();
    check_span("b2b", 8);
  endtask

  task automatic test_reset_mid();
    clear_stats();
    build_pkt(16'h0008, 1'b1, 6, 0, 2, 1'b1);
    drive_all();
    wait_drain();
    out_rdy = 8'hf7;
    build_pkt(16'h0008, 1'b1, 6, 2, 4, 1'b0);
    drive_all();
    repeat (3) @(negedge clk);
    checks++;
    if (out_wr !== '0) begin
      errors++;
      $display("FAIL mid_stall: got %h, required 00", out_wr);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if (out_wr !== '0) begin
      errors++;
      $display("FAIL mid_reset_out_wr: got %h, required 00", out_wr);
    end
    checks++;
    if (in_rdy !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset_in_rdy: got %b, required 1", in_rdy);
    end
`ifdef OUTPUT_PORT_DEMUX_DROP_CNT_EN
    checks++;
    if (num_pkts_dropped !== 32'd0) begin
      errors++;
      $display("FAIL mid_reset_drop_cnt: got %0d, required 0", num_pkts_dropped);
    end
`endif
    out_rdy = '1;
    repeat (3) @(negedge clk);
    clear_stats();
    build_pkt(16'h0002, 1'b1, 5, 0, 5, 1'b1);
    drive_all();
    wait_drain();
    check_span("after_reset", 5);
  endtask

  task automatic test_ignored_port();
    out_rdy = 8'h7f;
    clear_stats();
    build_pkt(16'h0001, 1'b1, 6, 0, 6, 1'b1);
    drive_all();
    wait_drain();
    check_span("ignored", 6);
    out_rdy = '1;
  endtask

  initial begin
    test_reset();
    test_unicast();
    test_multicast_stall();
    test_drop();
    test_back_to_back();
    test_reset_mid();
    test_ignored_port();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/output_port_demux.md
OUTPUT_PORT_DEMUX -- requirements
Module: output_port_demux

Interface
REQ-001 Parameter DATA_WIDTH, default 64, width of the packet data word.
REQ-002 Parameter CTRL_WIDTH, default DATA_WIDTH/8, width of the packet control word.
REQ-003 Parameter NUM_OUTPUT_QUEUES, default 8, number of output ports; legal range 1..16.
REQ-004 Parameter IO_QUEUE_STAGE_NUM, default 8'hff, ctrl value that marks the IOQ module header word.
REQ-005 Parameter DST_PORT_POS, default 0, LSB of the 16-bit one-hot destination-port field in the IOQ header.
REQ-006 Clock and reset: one clock; reset is synchronous and active-high.
REQ-007 clk  input  1  clock; all state changes on its rising edge.
REQ-008 reset  input  1  synchronous, active-high reset.
REQ-009 in_data  input  DATA_WIDTH  upstream packet word.
REQ-010 in_ctrl  input  CTRL_WIDTH  upstream control word.
REQ-011 in_wr  input  1  upstream word valid.
REQ-012 in_rdy  output  1  high when at least one more word can be accepted.
REQ-013 out_data  output  DATA_WIDTH  word broadcast to all ports.
REQ-014 out_ctrl  output  CTRL_WIDTH  control word broadcast to all ports.
REQ-015 out_wr  output  NUM_OUTPUT_QUEUES  per-port write strobe.
REQ-016 out_rdy  input  NUM_OUTPUT_QUEUES  per-port ready; ready means one more word can be accepted.

Function
REQ-017 An input FIFO of depth 4 SHALL buffer {in_ctrl, in_data}; in_rdy = NOT nearly_full, where nearly_full is asserted at 3 or more entries.
REQ-018 Packet framing SHALL be tracked by a two-state FSM, HDRS then PAYLOAD; HDRS->PAYLOAD when a word with ctrl==0 is read; PAYLOAD->HDRS when a word with ctrl!=0 (EOP) is read.
REQ-019 The first word read in HDRS after EOP or reset is the start of packet (SOP); if its ctrl==IO_QUEUE_STAGE_NUM, sel SHALL be loaded from data[DST_PORT_POS+NUM_OUTPUT_QUEUES-1:DST_PORT_POS]; otherwise sel SHALL be 0.
REQ-020 sel SHALL be held constant from SOP through EOP inclusive; the SOP word uses the newly decoded value.
REQ-021 A word SHALL be read from the FIFO when the FIFO is not empty AND every port with sel bit = 1 has out_rdy = 1 (a port with sel bit = 0 is ignored).
REQ-022 Words are delivered all-or-nothing: no port receives a word until every selected port is ready; multicast (more than one sel bit) is legal.
REQ-023 If sel==0, the packet SHALL be drained: one word read per cycle while the FIFO is not empty, and out_wr stays 0.
REQ-024 out_data, out_ctrl and out_wr SHALL be registered; a word read in cycle N appears in cycle N+1 with out_wr[i] = sel[i].
REQ-025 A sel bit at or above NUM_OUTPUT_QUEUES is outside the decoded field and SHALL be ignored.
REQ-026 Back-to-back packets SHALL incur no bubble: a SOP word may be read in the cycle immediately after the previous EOP.
REQ-027 A simultaneous FIFO write and read when the FIFO is full-minus-one SHALL not overflow; writes while full are a protocol violation and are discarded.

Reset
REQ-028 On reset: FIFO empty, FSM=HDRS, sel=0, out_wr=0, out_data=0, out_ctrl=0, in_rdy=1 from the next cycle.
REQ-029 Reset in mid-packet SHALL discard the partial packet; the next word read after reset is treated as SOP.

Configuration
REQ-030 Macro OUTPUT_PORT_DEMUX_DROP_CNT_EN: when defined, add output num_pkts_dropped (32-bit). It SHALL increment by 1 on each SOP with sel==0, saturate at 32'hffffffff, and reset to 0.
REQ-031 When OUTPUT_PORT_DEMUX_DROP_CNT_EN is undefined, the port and counter SHALL be absent; datapath behaviour SHALL be identical.

Verification
REQ-032 Unicast: 5-word packet, IOQ hdr dst=16'h0004, all out_rdy=1 -> 5 consecutive out_wr=8'h04 cycles, data matches input, latency 1 cycle after read.
REQ-033 Multicast stall: dst=16'h0011, out_rdy[4]=0 for 3 cycles -> no out_wr on any port during the stall; after release, words appear on ports 0 and 4 together.
REQ-034 Drop: first word ctrl=8'h00 or dst=0 -> zero out_wr for the whole packet; with the macro defined, num_pkts_dropped goes 0->1.
REQ-035 Back-to-back: packets to port 1 then port 6, in_wr continuous -> EOP on port 1 followed next cycle by SOP on port 6; no lost words.
REQ-036 Reset mid-packet: reset after word 2 of 6 -> out_wr=0; a following packet with dst=16'h0002 is delivered intact to port 1.
REQ-037 Ignored port: out_rdy[7]=0 while dst=16'h0001 -> port 0 receives the full packet at full rate.
